// File: rtl/sprite_vblank_update_scheduler.sv
// Sprite coordinate update scheduler: queues CPU writes and applies them only in vblank (frame_irq: SPRITE_SCHED_FRAME_IRQ_EN).
// Latency: vblank_start sampled at edge N gives first upd_we after edge N+1, then one update per cycle up to MAX_UPD.
// Backpressure: cmd_ready = !full; a command offered while full is discarded and flagged in sticky dropped.
module sprite_vblank_update_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_SPR    = 2,
    parameter int MAX_UPD    = 8,
    localparam int SW        = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [SW-1:0] cmd_sel,
    input  logic [7:0]    cmd_x,
    input  logic [7:0]    cmd_y,
    input  logic          vblank_start,
    input  logic          in_vblank,
    output logic          upd_we,
    output logic [SW-1:0] upd_sel,
    output logic [7:0]    upd_x,
    output logic [7:0]    upd_y,
    output logic [3:0]    pending,
    output logic          dropped,
    input  logic          clr_dropped,
    output logic          frame_irq
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [SW-1:0] sel;
        logic [7:0]    x;
        logic [7:0]    y;
    } cmd_t;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, DRAIN = 2'd2} state_t;

    state_t        state_q, state_d;
    cmd_t          mem_q [FIFO_DEPTH];
    cmd_t          cmd_in;
    cmd_t          upd_q, upd_d;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    budget_q, budget_d;
    logic          upd_we_q, upd_we_d;
    logic          dropped_q, dropped_d;
    logic          full, empty, push, pop;

    assign cmd_in    = {cmd_sel, cmd_x, cmd_y};
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    // Pops only while blanking is still active; a stalled drain falls back to ARMED.
    assign pop       = (state_q == DRAIN) && in_vblank && enable && !empty;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        dropped_d = dropped_q;
        if (clr_dropped) begin
            dropped_d = 1'b0;
        end
        if (cmd_valid && full) begin
            dropped_d = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        budget_d = budget_q;
        upd_we_d = 1'b0;
        upd_d    = upd_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (vblank_start && enable) begin
                    state_d  = DRAIN;
                    budget_d = 8'd0;
                end
            end
            DRAIN: begin
                if (pop) begin
                    upd_we_d = 1'b1;
                    upd_d    = mem_q[rd_ptr_q];
                    budget_d = budget_q + 8'd1;
                    if (count_q == CW'(1) && !push) begin
                        state_d = IDLE;
                    end else if (budget_q + 8'd1 == 8'(MAX_UPD)) begin
                        state_d = ARMED;
                    end
                end else begin
                    state_d = empty ? IDLE : ARMED;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            budget_q  <= '0;
            upd_we_q  <= 1'b0;
            upd_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            budget_q  <= budget_d;
            upd_we_q  <= upd_we_d;
            upd_q     <= upd_d;
            dropped_q <= dropped_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    always_comb begin
        if (32'(count_q) > 32'd15) begin
            pending = 4'hF;
        end else begin
            pending = 4'(count_q);
        end
    end

    assign upd_we  = upd_we_q;
    assign upd_sel = upd_q.sel;
    assign upd_x   = upd_q.x;
    assign upd_y   = upd_q.y;
    assign dropped = dropped_q;

`ifdef SPRITE_SCHED_FRAME_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if (clr_dropped) begin
            irq_d = 1'b0;
        end
        if (state_q == DRAIN && state_d == IDLE) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign frame_irq = irq_q;
`else
    assign frame_irq = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_vblank_update_scheduler.sv
// Directed bench for sprite_vblank_update_scheduler with MAX_UPD=3; strobes are checked against a queue of accepted commands.
module tb_sprite_vblank_update_scheduler;
    localparam int SW = 1;

`ifdef SPRITE_SCHED_FRAME_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n, enable, cmd_valid, cmd_ready, vblank_start, in_vblank;
    logic          upd_we, dropped, clr_dropped, frame_irq;
    logic [SW-1:0] cmd_sel, upd_sel;
    logic [7:0]    cmd_x, cmd_y, upd_x, upd_y;
    logic [3:0]    pending;

    int            checks   = 0;
    int            failures = 0;
    int            strobes  = 0;
    int            base;
    logic [16:0]   exp_q[$];
    logic [16:0]   mon_exp;

    always #5 clk = ~clk;

    sprite_vblank_update_scheduler #(
        .FIFO_DEPTH(4),
        .NUM_SPR   (2),
        .MAX_UPD   (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_sel     (cmd_sel),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .vblank_start(vblank_start),
        .in_vblank   (in_vblank),
        .upd_we      (upd_we),
        .upd_sel     (upd_sel),
        .upd_x       (upd_x),
        .upd_y       (upd_y),
        .pending     (pending),
        .dropped     (dropped),
        .clr_dropped (clr_dropped),
        .frame_irq   (frame_irq)
    );

    // Every strobe must match the oldest accepted command still outstanding.
    always @(negedge clk) begin
        if (upd_we === 1'b1) begin
            strobes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $error("FAIL strobe_unexpected got=%h exp=none", {upd_sel, upd_x, upd_y});
            end else begin
                mon_exp = exp_q.pop_front();
                assert ({upd_sel, upd_x, upd_y} === mon_exp) else begin
                    failures++;
                    $error("FAIL strobe_data got=%h exp=%h", {upd_sel, upd_x, upd_y}, mon_exp);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic s, input logic [7:0] x, input logic [7:0] y, input logic accept);
        cmd_valid = 1'b1;
        cmd_sel   = s;
        cmd_x     = x;
        cmd_y     = y;
        if (accept) exp_q.push_back({s, x, y});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_vb();
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_dropped = 1'b1;
        tick();
        clr_dropped = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_sel = '0; cmd_x = '0; cmd_y = '0;
        vblank_start = 1'b0; in_vblank = 1'b0; clr_dropped = 1'b0;
        ticks(2);
        check("rst_upd_we", upd_we, 0);
        check("rst_pending", pending, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_dropped", dropped, 0);
        check("rst_upd_x", upd_x, 0);
        check("rst_frame_irq", frame_irq, 0);
        rst_n = 1'b1;
        tick();

        // Basic drain: three updates in order, first one two cycles after the pulse.
        push(1'b0, 8'd10, 8'd20, 1'b1);
        push(1'b1, 8'd30, 8'd40, 1'b1);
        push(1'b0, 8'd50, 8'd60, 1'b1);
        check("t1_pending3", pending, 3);
        in_vblank = 1'b1;
        base = strobes;
        pulse_vb();
        check("t1_no_strobe_yet", upd_we, 0);
        tick();
        check("t1_first_strobe", upd_we, 1);
        ticks(3);
        check("t1_strobe_end", upd_we, 0);
        check("t1_strobes", strobes - base, 3);
        check("t1_pending0", pending, 0);
        check("t1_irq", frame_irq, IRQ_EN);
        check("t1_hold_x", upd_x, 50);
        in_vblank = 1'b0;
        pulse_clr();
        check("t1_irq_clr", frame_irq, 0);

        // Fill, overflow with coincident clear (set wins), then clear.
        push(1'b0, 8'd1, 8'd2, 1'b1);
        push(1'b1, 8'd3, 8'd4, 1'b1);
        push(1'b0, 8'd5, 8'd6, 1'b1);
        push(1'b1, 8'd7, 8'd8, 1'b1);
        check("t2_full_ready", cmd_ready, 0);
        check("t2_full_pending", pending, 4);
        check("t2_no_drop_yet", dropped, 0);
        clr_dropped = 1'b1;
        push(1'b0, 8'd99, 8'd99, 1'b0);
        clr_dropped = 1'b0;
        check("t2_dropped_set_wins", dropped, 1);
        check("t2_pending_after_drop", pending, 4);
        pulse_clr();
        check("t2_dropped_clr", dropped, 0);

        // Budget of 3 leaves one entry for the following frame.
        in_vblank = 1'b1;
        base = strobes;
        pulse_vb();
        ticks(6);
        check("t2_budget_strobes", strobes - base, 3);
        check("t2_budget_pending", pending, 1);
        check("t2_budget_irq", frame_irq, 0);
        in_vblank = 1'b0;
        ticks(2);
        in_vblank = 1'b1;
        base = strobes;
        pulse_vb();
        ticks(4);
        check("t2_next_frame_strobes", strobes - base, 1);
        check("t2_next_frame_pending", pending, 0);
        check("t2_hold_x", upd_x, 7);
        check("t2_next_frame_irq", frame_irq, IRQ_EN);
        in_vblank = 1'b0;
        pulse_clr();

        // Blanking ends after the first pop.
        push(1'b0, 8'd100, 8'd101, 1'b1);
        push(1'b1, 8'd102, 8'd103, 1'b1);
        push(1'b0, 8'd104, 8'd105, 1'b1);
        in_vblank = 1'b1;
        base = strobes;
        pulse_vb();
        tick();
        in_vblank = 1'b0;
        ticks(4);
        check("t3_strobes", strobes - base, 1);
        check("t3_pending", pending, 2);

        // Push and pop together at pending=2; budget restarts for the new frame.
        in_vblank = 1'b1;
        base = strobes;
        pulse_vb();
        push(1'b1, 8'd200, 8'd150, 1'b1);
        check("t4_pending_steady", pending, 2);
        ticks(5);
        check("t4_strobes", strobes - base, 3);
        check("t4_pending0", pending, 0);
        check("t4_hold_y", upd_y, 150);
        check("t4_irq", frame_irq, IRQ_EN);
        in_vblank = 1'b0;
        pulse_clr();

        // Reset in the middle of a drain.
        push(1'b0, 8'd11, 8'd12, 1'b1);
        push(1'b1, 8'd13, 8'd14, 1'b1);
        push(1'b0, 8'd15, 8'd16, 1'b1);
        in_vblank = 1'b1;
        base = strobes;
        pulse_vb();
        tick();
        check("t5_strobing", upd_we, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_upd_we", upd_we, 0);
        check("t5_rst_pending", pending, 0);
        check("t5_rst_ready", cmd_ready, 1);
        check("t5_rst_irq", frame_irq, 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(5);
        check("t5_no_more_strobes", strobes - base, 0);
        check("t5_pending_after", pending, 0);

        // Disabled scheduler still accepts pushes but never drains.
        enable = 1'b0;
        push(1'b1, 8'd250, 8'd191, 1'b1);
        check("t6_push_disabled", pending, 1);
        base = strobes;
        pulse_vb();
        ticks(4);
        check("t6_no_drain_disabled", strobes - base, 0);
        check("t6_pending_kept", pending, 1);
        enable = 1'b1;
        pulse_vb();
        ticks(4);
        check("t6_drain_enabled", strobes - base, 1);
        check("t6_pending0", pending, 0);
        check("t6_hold_y", upd_y, 191);
        check("t6_irq_full_drain", frame_irq, IRQ_EN);
        in_vblank = 1'b0;
        tick();
        check("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
